// File: rtl/poly_add_sched_if.sv
// Bundle between the poly add sequencer and its environment: start/busy/done
// handshake, two synchronous read ports, the adder operands/sum and the result port.
interface poly_add_sched_if #(
  parameter int AW  = 8,
  parameter int A_W = 128,
  parameter int B_W = 32
);
  logic           start;
  logic [AW-1:0]  a_base;
  logic [AW-1:0]  b_base;
  logic [AW-1:0]  c_base;
  logic           busy;
  logic           done;
  logic           a_rd_en;
  logic [AW-1:0]  a_rd_addr;
  logic [A_W-1:0] a_rd_data;
  logic           b_rd_en;
  logic [AW-1:0]  b_rd_addr;
  logic [B_W-1:0] b_rd_data;
  logic [A_W-1:0] add_a;
  logic [B_W-1:0] add_b;
  logic [A_W-1:0] add_sum;
  logic           c_wr_en;
  logic [AW-1:0]  c_wr_addr;
  logic [A_W-1:0] c_wr_data;

  // Sequencer side
  modport master (
    input  start, a_base, b_base, c_base, a_rd_data, b_rd_data, add_sum,
    output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           add_a, add_b, c_wr_en, c_wr_addr, c_wr_data
  );

  // Environment side: top-level FSM, memories and the adder
  modport slave (
    output start, a_base, b_base, c_base, a_rd_data, b_rd_data, add_sum,
    input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
           add_a, add_b, c_wr_en, c_wr_addr, c_wr_data
  );
endinterface

// File: rtl/poly_add_sched.sv
// Streams NUM_WORDS a/b word pairs through the external adder and writes one sum
// per cycle; read in cycle 1+k, operands registered, sum registered, write in 4+k.
module poly_add_sched #(
  parameter int NUM_WORDS = 32,
  parameter int AW        = 8,
  parameter int A_W       = 128,
  parameter int B_W       = 32
) (
  input logic clk,
  input logic rst,
  poly_add_sched_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

  logic [1:0]     stateReg;
  logic [AW-1:0]  idxReg;
  logic           rdEnReg;
  logic [AW-1:0]  aRdAddrReg;
  logic [AW-1:0]  bRdAddrReg;
  logic           rdValidReg;
  logic           opValidReg;
  logic [A_W-1:0] addAReg;
  logic [B_W-1:0] addBReg;
  logic           cWrEnReg;
  logic [AW-1:0]  cWrAddrReg;
  logic [AW-1:0]  cNextReg;
  logic [A_W-1:0] cWrDataReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      idxReg     <= '0;
      rdEnReg    <= 1'b0;
      aRdAddrReg <= '0;
      bRdAddrReg <= '0;
      rdValidReg <= 1'b0;
      opValidReg <= 1'b0;
      addAReg    <= '0;
      addBReg    <= '0;
      cWrEnReg   <= 1'b0;
      cWrAddrReg <= '0;
      cNextReg   <= '0;
      cWrDataReg <= '0;
    end else begin
      // Three-stage valid chain: memory data, adder operands, result word
      rdValidReg <= rdEnReg;
      opValidReg <= rdValidReg;
      cWrEnReg   <= opValidReg;

      if (rdValidReg) begin
        addAReg <= bus.a_rd_data;
        addBReg <= bus.b_rd_data;
      end

      if (opValidReg) begin
        cWrDataReg <= bus.add_sum;
        cWrAddrReg <= cNextReg;
        cNextReg   <= cNextReg + 1'b1;
      end

      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            rdEnReg    <= 1'b1;
            aRdAddrReg <= bus.a_base;
            bRdAddrReg <= bus.b_base;
            cNextReg   <= bus.c_base;
            idxReg     <= '0;
            stateReg   <= RUN;
          end
        end
        RUN: begin
          if (idxReg == LAST_IDX) begin
            rdEnReg  <= 1'b0;
            stateReg <= DRAIN;
          end else begin
            idxReg     <= idxReg + 1'b1;
            aRdAddrReg <= aRdAddrReg + 1'b1;
            bRdAddrReg <= bRdAddrReg + 1'b1;
          end
        end
        DRAIN: begin
          // Last write is on the port now and nothing is left behind it
          if (cWrEnReg && !rdValidReg && !opValidReg) stateReg <= DONE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (stateReg == RUN) || (stateReg == DRAIN);
  assign bus.done      = (stateReg == DONE);
  assign bus.a_rd_en   = rdEnReg;
  assign bus.b_rd_en   = rdEnReg;
  assign bus.a_rd_addr = aRdAddrReg;
  assign bus.b_rd_addr = bRdAddrReg;
  assign bus.add_a     = addAReg;
  assign bus.add_b     = addBReg;
  assign bus.c_wr_en   = cWrEnReg;
  assign bus.c_wr_addr = cWrAddrReg;
  assign bus.c_wr_data = cWrDataReg;
endmodule
